fp_add_scheduler: RTL and testbench
===================================

// Module: fp_add_scheduler
// PURPOSE
//  Shares one fixed-latency, non-stallable pipelined FP32 adder among NUM_REQ requesters.
//  Round-robin arbitration issues at most one op per cycle. Optional subtract is done by flipping the sign of b.
//  A tag shift register tracks each op and routes the adder result back to its requester.
//  Sits between compute lanes and the shared adder, which it drives through add_a/add_b/add_result.
// PARAMETERS
//  NUM_REQ  4   number of requesters (>=2)
//  WIDTH    32  operand/result width (IEEE-754 single)
//  LATENCY  3   cycles from issue cycle to result cycle of the attached adder (>=1)
//  ID_W     $clog2(NUM_REQ)  requester id width (derived)
// PORTS
//  clk         in   1              clock
//  reset       in   1              synchronous, active-high; also wired to the adder's reset
//  req_valid   in   NUM_REQ        per-requester op request
//  req_op      in   NUM_REQ        0 = add (a+b), 1 = sub (a-b)
//  req_a       in   NUM_REQ*WIDTH  operand a, packed; requester i at [i*WIDTH +: WIDTH]
//  req_b       in   NUM_REQ*WIDTH  operand b, packed, same layout
//  req_ready   out  NUM_REQ        one-hot grant; fire_i = req_valid[i] & req_ready[i]
//  resp_valid  out  NUM_REQ        one-hot, 1-cycle pulse: result for requester i
//  resp_data   out  WIDTH          result; meaningful only when any resp_valid is set
//  add_a       out  WIDTH          adder operand a
//  add_b       out  WIDTH          adder operand b
//  add_result  in   WIDTH          adder registered result
//  in_flight   out  $clog2(LATENCY+1)  ops issued but not yet returned
//  busy        out  1              |req_valid | (in_flight != 0)
// BEHAVIOUR
//  Reset values: req_ready=0, resp_valid=0, resp_data=0, add_a=add_b=0, in_flight=0, busy=0.
//   Round-robin pointer ptr=0; all tag entries invalid.
//  Arbitration (combinational):
//   - Scan ids ptr, ptr+1, ... (mod NUM_REQ); grant the first with req_valid set.
//   - req_ready is asserted only for that id and depends on req_valid.
//   - Requesters hold valid, operands and op stable until fire; no response backpressure
//     (resp is fire-and-forget, requester must sample it).
//  Pointer update on the edge: on a fire by id g, ptr <= (g+1) % NUM_REQ. With no fire, ptr holds.
//  Issue (combinational, same cycle as fire):
//   - add_a = req_a[g].
//   - add_b = req_b[g] with bit WIDTH-1 inverted when req_op[g]=1.
//   - With no fire, add_a = add_b = 0 (the adder computes 0+0; its result is discarded).
//  Tag pipe: LATENCY entries {vld, id}. Every edge: tag[0] <= {fire, g}; tag[k] <= tag[k-1].
//   An op fired in cycle t is at tag[LATENCY-1] during cycle t+LATENCY.
//  Response (combinational):
//   - When tag[LATENCY-1].vld: resp_valid[id]=1 and resp_data=add_result. Otherwise all zero.
//   - Responses return in issue order; throughput is one op/cycle sustained.
//  in_flight: incremented on fire, decremented when the tail tag is valid. Simultaneous
//   issue+retire leaves it unchanged. Max value LATENCY, so it never wraps.
//  Reset mid-operation: all tags are cleared and in-flight ops never respond; ptr=0.
//   The adder is reset by the same signal. The first issue is allowed in the cycle after reset deasserts.
//  The same requester may be granted on consecutive cycles if it is the only one valid.
//  Sign-flip on sub applies to NaN/zero inputs too; the block performs no IEEE special-casing.
// STRUCTURE
//  Package fp_sched_pkg:
//   - typedef struct packed {logic vld; logic [ID_W-1:0] id;} tag_t
//   - localparam OP_ADD=1'b0, OP_SUB=1'b1
//   - localparam FP_SIGN_BIT=31
//  Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs a one-hot gnt, a gnt_id and any_gnt.
//   It is purely combinational; the pointer register stays in fp_add_scheduler.
//  The adder is instantiated outside this block (one level up), so the bench can substitute a stub.
// TESTING  (bench adder stub: LATENCY-stage pipe, result = add_a + add_b as integers, sync reset)
//  1. Only req0 valid, a=32'h10, b=32'h20, op=add in cycle 0.
//     -> req_ready[0]=1 in cycle 0; resp_valid=4'b0001 with resp_data=32'h30 in cycle 3, and only then.
//  2. req_valid=4'b1111 held for 8 cycles.
//     -> grants in order 0,1,2,3,0,1,2,3 one per cycle; resp ids return in the same order from cycle 3 on;
//     in_flight goes 1,2,3, then stays 3.
//  3. req1 op=sub, a=32'h3F800000, b=32'h40000000.
//     -> add_b=32'hC0000000 in the fire cycle; resp_valid=4'b0010 in cycle t+3.
//  4. After a grant to id 2, req1 and req3 both valid.
//     -> id 3 granted first, then id 1; no fire and valid=0 in between leaves ptr unchanged.
//  5. Fire two ops, then assert reset for 1 cycle.
//     -> no resp_valid ever for those ops; in_flight=0, busy=0; the next sole req0 is granted immediately.
//  6. Sole requester req2 valid on cycles 0,1,2.
//     -> three back-to-back grants to id 2; three resp pulses on cycles 3,4,5 with the matching sums; busy falls in cycle 6.

Source files
------------

// File: rtl/fp_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_sched_pkg
//  Description : Shared types and constants for the FP32 adder scheduler.
//                tag_t travels down the tag pipe alongside each issued op.
//                Its id field is sized for the largest supported requester
//                count. Users place the real id in the low bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_sched_pkg;

    // Upper bound on requester id width carried in a tag.
    localparam int MAX_ID_W = 8;

    typedef struct packed {
        logic                vld;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int FP_SIGN_BIT = 31;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin arbiter. Scans the request
//                vector starting at ptr and wrapping modulo N. Grants the
//                first active requester. The pointer register is kept by
//                the caller.
//  Ports       : req     [N-1:0]    request vector
//                ptr     [ID_W-1:0] highest-priority id this cycle
//                gnt     [N-1:0]    one-hot grant
//                gnt_id  [ID_W-1:0] index of the granted requester
//                any_gnt            a grant was issued
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            any_gnt
);

    int              w_idx;
    logic [ID_W-1:0] w_idx_v;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        any_gnt = 1'b0;
        w_idx   = 0;
        w_idx_v = '0;
        for (int off = 0; off < N; off++) begin
            // Modular wrap done explicitly so non-power-of-two N works.
            w_idx = int'(ptr) + off;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            w_idx_v = ID_W'(w_idx);
            if (!any_gnt && req[w_idx_v]) begin
                any_gnt      = 1'b1;
                gnt[w_idx_v] = 1'b1;
                gnt_id       = w_idx_v;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_add_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_scheduler
//  Description : Shares one fixed-latency, non-stallable pipelined FP32
//                adder among NUM_REQ requesters. A round-robin arbiter issues
//                at most one op per cycle. Subtract is formed by flipping
//                the sign of b. A tag shift register routes each adder result
//                back to the requester that issued it.
//  Ports       : clk, reset (sync, active-high; also resets the adder)
//                req_valid/req_op/req_a/req_b   requester side (packed)
//                req_ready                      one-hot grant
//                resp_valid/resp_data           one-cycle result pulse
//                add_a/add_b/add_result         shared adder interface
//                in_flight                      ops issued, not yet returned
//                busy                           any request or op in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_add_scheduler
    import fp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_op,
    input  logic [NUM_REQ*WIDTH-1:0]     req_a,
    input  logic [NUM_REQ*WIDTH-1:0]     req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           resp_valid,
    output logic [WIDTH-1:0]             resp_data,
    output logic [WIDTH-1:0]             add_a,
    output logic [WIDTH-1:0]             add_b,
    input  logic [WIDTH-1:0]             add_result,
    output logic [$clog2(LATENCY+1)-1:0] in_flight,
    output logic                         busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LATENCY+1);
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    logic [ID_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_any_gnt;
    logic               w_fire;
    tag_t               r_tag [LATENCY];
    logic [CNT_W-1:0]   r_in_flight;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_id  (w_gnt_id),
        .any_gnt (w_any_gnt)
    );

    // No grants while reset is held. The first issue happens the cycle after release.
    assign w_fire    = w_any_gnt & ~reset;
    assign req_ready = reset ? '0 : w_gnt;

    // Operand mux. It drives zeros when idle so the adder sees a quiet 0+0.
    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_fire && w_gnt[i]) begin
                add_a = req_a[i*WIDTH +: WIDTH];
                add_b = req_b[i*WIDTH +: WIDTH] ^
                        ((req_op[i] == OP_SUB) ? SIGN_MASK : '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_fire) begin
            r_ptr <= (w_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_id + 1'b1;
        end
    end

    // Tag pipe mirrors the adder's depth. The tail entry lines up with add_result.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0].vld <= w_fire;
            r_tag[0].id  <= MAX_ID_W'(w_gnt_id);
            for (int k = 1; k < LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        if (r_tag[LATENCY-1].vld && !reset) begin
            resp_valid[r_tag[LATENCY-1].id[ID_W-1:0]] = 1'b1;
            resp_data                                  = add_result;
        end
    end

    // Bounded by LATENCY. An issue in the same cycle as a retire cancels out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_flight <= '0;
        end else begin
            case ({w_fire, r_tag[LATENCY-1].vld})
                2'b10:   r_in_flight <= r_in_flight + 1'b1;
                2'b01:   r_in_flight <= r_in_flight - 1'b1;
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    assign in_flight = r_in_flight;
    assign busy      = ~reset & ((|req_valid) | (r_in_flight != '0));

endmodule
`default_nettype wire

// File: tb/tb_fp_add_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_add_scheduler
//  Description : Self-checking bench for fp_add_scheduler. It contains a
//                LATENCY-stage integer adder stub and a reference model. The
//                model uses a round-robin scan and a queue of outstanding ops
//                with their due cycles. Directed scenarios run first, then
//                randomized traffic with sporadic resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_scheduler;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_op;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_data;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_result;
    logic [1:0]     in_flight;
    logic           busy;

    always #5 clk = ~clk;

    fp_add_scheduler #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .in_flight  (in_flight),
        .busy       (busy)
    );

    // Adder stub: integer sum delayed by LAT registers, sync reset.
    logic [W-1:0] pipe [LAT];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LAT; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= add_a + add_b;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
    end
    assign add_result = pipe[LAT-1];

    // Reference model state
    typedef struct {
        int          id;
        logic [31:0] sum;
        int          due;
    } ent_t;

    ent_t q[$];
    int   mptr;
    int   cyc;
    int   vectors;
    int   miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Starts at a negedge with the inputs applied. Checks the outputs,
    // advances one clock, updates the model, and drops the fired
    // requester's valid at the next negedge.
    task automatic run_cycle();
        int          g;
        int          id;
        logic [31:0] ea, eb, edata;
        logic [3:0]  eready, eresp;
        logic        ebusy;
        #1;
        g = -1;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                id = (mptr + k) % N;
                if (g < 0 && req_valid[id]) g = id;
            end
        end
        eready = 4'b0;
        ea     = 32'h0;
        eb     = 32'h0;
        if (g >= 0) begin
            eready = 4'b1 << g;
            ea     = req_a[g*W +: W];
            eb     = req_b[g*W +: W] ^ (req_op[g] ? 32'h8000_0000 : 32'h0);
        end
        eresp = 4'b0;
        edata = 32'h0;
        if (!reset && q.size() > 0 && q[0].due == cyc) begin
            eresp = 4'b1 << q[0].id;
            edata = q[0].sum;
        end
        ebusy = !reset && (req_valid != 4'b0 || q.size() != 0);

        chk("req_ready",  32'(req_ready),  32'(eready));
        chk("add_a",      add_a,           ea);
        chk("add_b",      add_b,           eb);
        chk("resp_valid", 32'(resp_valid), 32'(eresp));
        chk("resp_data",  resp_data,       edata);
        chk("in_flight",  32'(in_flight),  32'(q.size()));
        chk("busy",       32'(busy),       32'(ebusy));

        @(posedge clk);
        if (reset) begin
            q.delete();
            mptr = 0;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back('{g, ea + eb, cyc + LAT});
                mptr = (g + 1) % N;
            end
        end
        cyc++;
        @(negedge clk);
        if (g >= 0) req_valid[g] = 1'b0;
    endtask

    task automatic arm(input int i, input logic op, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]     = 1'b1;
        req_op[i]        = op;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
    endtask

    task automatic arm_rand(input int i);
        arm(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) run_cycle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        mptr        = 0;
        reset       = 1'b1;
        req_valid   = '0;
        req_op      = '0;
        req_a       = '0;
        req_b       = '0;
        @(negedge clk);
        idle(2);
        reset = 1'b0;

        // 1: single add from requester 0; result 0x30 three cycles later
        arm(0, 1'b0, 32'h10, 32'h20);
        run_cycle();
        idle(5);

        // 2: all four requesters continuously valid for 8 cycles
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) if (!req_valid[i]) arm_rand(i);
            run_cycle();
        end
        idle(8);

        // 3: subtract flips the sign of b on the adder port
        arm(1, 1'b1, 32'h3F80_0000, 32'h4000_0000);
        run_cycle();
        idle(4);

        // 4: after a grant to 2 and an idle gap, 3 wins over 1
        arm(2, 1'b0, 32'h1, 32'h2);
        run_cycle();
        idle(1);
        arm(1, 1'b0, 32'h100, 32'h200);
        arm(3, 1'b1, 32'h300, 32'h400);
        run_cycle();
        run_cycle();
        idle(4);

        // 5: reset with two ops in flight; they never respond
        arm(0, 1'b0, 32'h5, 32'h6);
        run_cycle();
        arm(1, 1'b0, 32'h7, 32'h8);
        run_cycle();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        arm(0, 1'b0, 32'h9, 32'hA);
        run_cycle();
        idle(5);

        // 6: sole requester 2, back-to-back issues
        for (int c = 0; c < 3; c++) begin
            arm(2, 1'($urandom_range(0, 1)), $urandom, $urandom);
            run_cycle();
        end
        idle(5);

        // Randomized traffic with occasional reset
        repeat (400) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) arm_rand(i);
            end
            run_cycle();
        end
        reset = 1'b0;
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
